// File: rtl/uart_cmd_framer.sv
// rtl/uart_cmd_framer.sv - framed UART byte stream to command word with checksum, timeout and holding slot
module uart_cmd_framer #(
    parameter int         DATA_W      = 32,
    parameter int         N_OPERANDS  = 2,
    parameter int         OP_W        = 2,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 1_000_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic [OP_W-1:0]              cmd_op,
    output logic [N_OPERANDS*DATA_W-1:0] cmd_data,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic                         err_valid,
    output logic [1:0]                   err_code,
    output logic                         busy
);

    localparam int W       = N_OPERANDS * DATA_W;
    localparam int N_BYTES = W / 8;
    localparam int CNT_W   = $clog2(N_BYTES + 1);
    localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(N_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPC,
        S_DATA,
        S_CSUM
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [7:0]       xor_q, xor_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [W-1:0]     sh_q, sh_d;
    logic [OP_W-1:0]  cmd_op_q, cmd_op_d;
    logic [W-1:0]     cmd_data_q, cmd_data_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             err_valid_q, err_valid_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             timeout;
    logic             slot_free;

    // Inside a frame, the idle counter expiring wins only if no byte arrives that cycle.
    assign timeout   = (state_q != S_IDLE) && !rx_valid && (to_q == TO_LAST);
    // A handshake in this cycle frees the slot for a frame completing on the same edge.
    assign slot_free = !cmd_valid_q || cmd_ready;

    // Next-state: frame parser, idle timer and holding-slot update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        xor_d       = xor_q;
        op_d        = op_q;
        sh_d        = sh_q;
        cmd_op_d    = cmd_op_q;
        cmd_data_d  = cmd_data_q;
        cmd_valid_d = cmd_valid_q && !cmd_ready;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;

        if (state_q == S_IDLE || rx_valid) begin
            to_d = '0;
        end else begin
            to_d = to_q + 1'b1;
        end

        if (timeout) begin
            state_d     = S_IDLE;
            to_d        = '0;
            err_valid_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
        end else if (rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = S_OPC;
                    end
                end
                S_OPC: begin
                    op_d    = rx_data[OP_W-1:0];
                    xor_d   = rx_data;
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    sh_d  = (sh_q << 8) | W'(rx_data);
                    xor_d = xor_q ^ rx_data;
                    if (cnt_q == LAST_BYTE) begin
                        state_d = S_CSUM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_CSUM: begin
                    state_d = S_IDLE;
                    if (rx_data != xor_q) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                    end else if (slot_free) begin
                        cmd_op_d    = op_q;
                        cmd_data_d  = sh_q;
                        cmd_valid_d = 1'b1;
                    end else begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_OVERRUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers; reset discards any partial frame and the held command.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            to_q        <= '0;
            xor_q       <= '0;
            op_q        <= '0;
            sh_q        <= '0;
            cmd_op_q    <= '0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            to_q        <= to_d;
            xor_q       <= xor_d;
            op_q        <= op_d;
            sh_q        <= sh_d;
            cmd_op_q    <= cmd_op_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign cmd_op    = cmd_op_q;
    assign cmd_data  = cmd_data_q;
    assign cmd_valid = cmd_valid_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/uart_cmd_framer.md
# uart_cmd_framer

Parametrised command framer between the UART byte receiver and the command state machine that drives the I2C master. Assembles a framed byte stream into one command word: opcode plus N operands of configurable width, replacing the fixed 66-bit `{2-bit op, 32-bit, 32-bit}` packing. Adds sync-byte framing, XOR checksum, inter-byte timeout and a valid/ready output handshake with a one-entry holding register.

## Interface
Parameters:
- `DATA_W`, 32: operand width in bits. Must be a multiple of 8 and at least 8.
- `N_OPERANDS`, 2: operands per frame. Must be at least 1.
- `OP_W`, 2: opcode width in bits. Range 1–8.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CYC`, 1_000_000: idle cycles allowed between bytes inside a frame.

Ports:
- `clk` in 1: system clock. The block uses this single clock.
- `reset` in 1: synchronous, active-high reset.
- `rx_data` in 8: received UART byte.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `cmd_op` out OP_W: opcode of the held command.
- `cmd_data` out N_OPERANDS*DATA_W: operands; operand 0 is in the MSBs.
- `cmd_valid` out 1: held command available.
- `cmd_ready` in 1: consumer accepts the command.
- `err_valid` out 1: one-cycle error pulse.
- `err_code` out 2: 01 = checksum, 10 = timeout, 11 = overrun. Held until the next error.
- `busy` out 1: high when the state is not IDLE.

## Operation
- Frame format: SYNC_BYTE, then OP byte, then N_OPERANDS*DATA_W/8 operand bytes (MSB first, operand 0 first), then CSUM byte.
- CSUM is the XOR of the OP byte and all operand bytes.
- `cmd_op` takes OP byte[OP_W-1:0]; the upper OP bits are ignored.
- States:
  - IDLE: a byte equal to SYNC_BYTE moves to OPC. All other bytes are dropped silently.
  - OPC: the next byte loads the opcode and seeds the running XOR. Moves to DATA.
  - DATA: each byte shifts into the operand shift register and updates the XOR. A byte counter moves to CSUM after the last operand byte.
  - CSUM: on the next byte, compare it with the running XOR.
    - Match and holding slot free: load the slot.
    - Match and slot occupied: drop the frame and raise overrun.
    - Mismatch: drop the frame and raise checksum error.
    - All cases return to IDLE.
- Inside a frame, SYNC_BYTE is ordinary data; there is no resynchronisation.
- Holding slot:
  - `cmd_valid` stays high and `cmd_op`/`cmd_data` stay stable until a cycle with `cmd_valid & cmd_ready`.
  - Assembly of the next frame continues while the slot is full.
- Timeout:
  - A counter clears on every `rx_valid` and increments while the state is not IDLE.
  - When it reaches TIMEOUT_CYC, the state goes to IDLE and the block raises `err_valid` with `err_code` = 10.
  - The counter is held at 0 in IDLE.
- Reset clears:
  - state to IDLE;
  - the counters;
  - `cmd_valid`, `err_valid` and `busy` to 0;
  - `err_code`, `cmd_op` and `cmd_data` to 0.
- Reset during a frame discards the frame. Reset with `cmd_valid` high discards the held command.

## Timing
- `cmd_valid` rises in the cycle after the `rx_valid` cycle of a good CSUM byte.
- `err_valid` is high for exactly one cycle, in the cycle after the CSUM byte or after the timeout count is reached.
- A handshake (`cmd_valid & cmd_ready`) drops `cmd_valid` in the next cycle unless a new good frame loads in that same edge.
- A completing good frame in the same cycle as the handshake is loaded, with no overrun. `cmd_valid` stays high with the new contents.
- `rx_valid` in the same cycle the counter would hit TIMEOUT_CYC: the byte wins. It is processed and the counter clears.
- Back-to-back `rx_valid` on consecutive cycles is supported; each byte is consumed in one cycle.
- `busy` rises in the cycle after SYNC is accepted and falls in the cycle after CSUM or timeout.

## Test plan
- Good frame (default parameters), hold `cmd_ready`=1.
  - Stimulus: bytes A5 01 40 A0 00 00 40 40 00 00 E1.
  - Required: `cmd_op`=2'b01, `cmd_data`=64'h40A00000_40400000, `cmd_valid` high the cycle after E1, no `err_valid`.
- Bad checksum: same frame with CSUM 0xE0.
  - Required: `err_valid` pulse with `err_code`=01; `cmd_valid` stays 0; `busy` low afterwards.
- Overrun.
  - Stimulus: `cmd_ready`=0; send the good frame twice.
  - Required: first frame held; second frame gives `err_code`=11; `cmd_data` still holds the first frame.
  - Then assert `cmd_ready` for 1 cycle: `cmd_valid` falls the next cycle.
- Timeout, with TIMEOUT_CYC=16.
  - Stimulus: send A5 01 40, then idle 16 cycles.
  - Required: `err_code`=10 pulse on the cycle after the count is reached; state IDLE; a following good frame is accepted.
  - Repeat with a byte arriving at cycle 16: no error.
- Parametric build DATA_W=16, N_OPERANDS=3, OP_W=4.
  - Stimulus: A5 0F 12 34 56 78 9A BC CSUM, where CSUM = XOR of 0F through BC.
  - Required: `cmd_op`=4'hF, `cmd_data`=48'h1234_5678_9ABC. Also: noise bytes 00 FF before A5 are ignored.
- Mid-frame reset: assert `reset` one cycle after operand byte 3.
  - Required: all outputs 0 the next cycle; the remaining bytes (no SYNC) are ignored; a subsequent full frame is accepted.
